// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller states and default MISR constants.
// Shared by the response analyser and the pattern generator.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPACT,
    COMPARE,
    DONE
  } state_t;

  localparam int          DEF_MISR_W = 16;
  localparam logic [15:0] DEF_POLY   = 16'h6801;
  localparam logic [15:0] DEF_SEED   = 16'hFFFF;

endpackage

// File: rtl/bist_misr_core.sv
// Galois left-shift MISR with synchronous seed load and update enable.
// Parallel data is XORed into the shifted value on every enabled cycle.
module bist_misr_core #(
  parameter int             W    = 16,
  parameter logic [W-1:0]   POLY = '0,
  parameter logic [W-1:0]   SEED = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_sig
);

  logic [W-1:0] r_sig;
  logic [W-1:0] w_next;

  always_comb begin
    w_next = {r_sig[W-2:0], 1'b0} ^ i_data;
    if (r_sig[W-1]) w_next = w_next ^ POLY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (i_load) begin
      r_sig <= SEED;
    end else if (i_en) begin
      r_sig <= w_next;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/bist_resp_misr.sv
// BIST output response analyser: MISR compaction and golden compare.
// Define BIST_TIMEOUT_EN to add the idle-response watchdog and timeout port.
module bist_resp_misr
  import bist_pkg::*;
#(
  parameter int                  MISR_W = DEF_MISR_W,
  parameter logic [MISR_W-1:0]   POLY   = MISR_W'(DEF_POLY),
  parameter logic [MISR_W-1:0]   SEED   = MISR_W'(DEF_SEED),
  parameter int                  N_PAT  = 256,
  parameter logic [MISR_W-1:0]   GOLDEN = '0
`ifdef BIST_TIMEOUT_EN
  ,
  parameter int                  TIMEOUT = 1024
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              resp_valid,
  input  logic              resp_synced,
  input  logic              resp_err,
  output logic [MISR_W-1:0] signature,
  output logic              busy,
  output logic              pass_fail,
`ifdef BIST_TIMEOUT_EN
  output logic              timeout,
`endif
  output logic              bist_end
);

  localparam int CW = $clog2(N_PAT + 1);

  state_t      r_state;
  state_t      w_next;
  logic [CW-1:0] r_count;
  logic        r_pass;
  logic        r_end;
  logic        w_load;
  logic        w_upd;
  logic        w_cmp;
  logic        w_clr;
  logic        w_last;
  logic [MISR_W-1:0] w_data;

  assign w_last = (r_count == CW'(N_PAT - 1));
  assign w_data = {{(MISR_W-2){1'b0}}, resp_err, resp_synced};

`ifdef BIST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wd;
  logic          r_to;
  logic          w_to;
  assign w_to    = (r_state == COMPACT) && !resp_valid
                && (r_wd == TW'(TIMEOUT - 1));
  assign timeout = r_to;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_upd  = 1'b0;
    w_cmp  = 1'b0;
    w_clr  = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next = LOAD;
          w_clr  = 1'b1;
        end
      end
      LOAD: begin
        w_load = 1'b1;
        w_next = COMPACT;
      end
      COMPACT: begin
        if (resp_valid) begin
          w_upd = 1'b1;
          if (w_last) w_next = COMPARE;
        end
`ifdef BIST_TIMEOUT_EN
        else if (w_to) begin
          w_next = DONE;
        end
`endif
      end
      COMPARE: begin
        w_cmp  = 1'b1;
        w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_count <= '0;
      r_pass  <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      if (w_clr || w_load) begin
        r_pass <= 1'b0;
        r_end  <= 1'b0;
      end
      if (w_load) r_count <= '0;
      if (w_upd)  r_count <= r_count + 1'b1;
      if (w_cmp) begin
        r_pass <= (signature == GOLDEN);
        r_end  <= 1'b1;
      end
`ifdef BIST_TIMEOUT_EN
      if (w_to) begin
        r_pass <= 1'b0;
        r_end  <= 1'b1;
      end
`endif
    end
  end

`ifdef BIST_TIMEOUT_EN
  // Watchdog counts consecutive empty COMPACT cycles only.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_wd <= '0;
      r_to <= 1'b0;
    end else begin
      if (w_clr || w_load) r_to <= 1'b0;
      if (w_to)            r_to <= 1'b1;
      if (r_state != COMPACT || resp_valid) r_wd <= '0;
      else                                  r_wd <= r_wd + 1'b1;
    end
  end
`endif

  bist_misr_core #(
    .W    (MISR_W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk    (CLK),
    .rst_n  (RST),
    .i_load (w_load),
    .i_en   (w_upd),
    .i_data (w_data),
    .o_sig  (signature)
  );

  assign busy      = (r_state == LOAD) || (r_state == COMPACT)
                  || (r_state == COMPARE);
  assign pass_fail = r_pass;
  assign bist_end  = r_end;

endmodule

// File: tb/tb_bist_resp_misr.sv
// Directed bench for bist_resp_misr with N_PAT = 1, 2 and 4 instances.
module tb_bist_resp_misr;

  logic CLK = 1'b0;
  logic RST;
  logic start, valid, syn, err;

  logic [15:0] sig1, sig2, sig4;
  logic busy1, busy2, busy4;
  logic pf1, pf2, pf4;
  logic end1, end2, end4;
`ifdef BIST_TIMEOUT_EN
  logic to1, to2, to4;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  bist_resp_misr #(.N_PAT(1), .GOLDEN(16'h97FF)
`ifdef BIST_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) u1 (
    .CLK(CLK), .RST(RST), .start(start), .resp_valid(valid),
    .resp_synced(syn), .resp_err(err), .signature(sig1),
    .busy(busy1), .pass_fail(pf1),
`ifdef BIST_TIMEOUT_EN
    .timeout(to1),
`endif
    .bist_end(end1));

  bist_resp_misr #(.N_PAT(2), .GOLDEN(16'h47FC)) u2 (
    .CLK(CLK), .RST(RST), .start(start), .resp_valid(valid),
    .resp_synced(syn), .resp_err(err), .signature(sig2),
    .busy(busy2), .pass_fail(pf2),
`ifdef BIST_TIMEOUT_EN
    .timeout(to2),
`endif
    .bist_end(end2));

  bist_resp_misr #(.N_PAT(4), .GOLDEN(16'h77FE)) u4 (
    .CLK(CLK), .RST(RST), .start(start), .resp_valid(valid),
    .resp_synced(syn), .resp_err(err), .signature(sig4),
    .busy(busy4), .pass_fail(pf4),
`ifdef BIST_TIMEOUT_EN
    .timeout(to4),
`endif
    .bist_end(end4));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    tick();
    RST = 1'b1;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    start = 0; valid = 0; syn = 0; err = 0;
    RST = 1'b0;
    tick();
    tick();
    n_chk++;
    if (sig1 !== 16'h0000) $display("FAIL rst_sig got %h want 0000", sig1);
    else n_pass++;
    n_chk++;
    if (busy1 !== 1'b0) $display("FAIL rst_busy got %b want 0", busy1);
    else n_pass++;
    n_chk++;
    if (pf1 !== 1'b0) $display("FAIL rst_pf got %b want 0", pf1);
    else n_pass++;
    n_chk++;
    if (end1 !== 1'b0) $display("FAIL rst_end got %b want 0", end1);
    else n_pass++;
    RST = 1'b1;
  endtask

  task automatic test_single_pass();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if (busy1 !== 1'b1) $display("FAIL load_busy got %b want 1", busy1);
    else n_pass++;
    tick();
    n_chk++;
    if (sig1 !== 16'hFFFF) $display("FAIL seed got %h want FFFF", sig1);
    else n_pass++;
    valid = 1; syn = 0; err = 0;
    tick();
    valid = 0;
    n_chk++;
    if (sig1 !== 16'h97FF || end1 !== 1'b0)
      $display("FAIL sp_cap got %h/%b want 97FF/0", sig1, end1);
    else n_pass++;
    tick();
    n_chk++;
    if (end1 !== 1'b1 || pf1 !== 1'b1 || busy1 !== 1'b0)
      $display("FAIL sp_done got end=%b pf=%b busy=%b want 1 1 0",
               end1, pf1, busy1);
    else n_pass++;
    tick();
    n_chk++;
    if (end1 !== 1'b1 || sig1 !== 16'h97FF)
      $display("FAIL sp_hold got %h/%b want 97FF/1", sig1, end1);
    else n_pass++;
  endtask

  task automatic test_single_fail();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if (end1 !== 1'b0) $display("FAIL restart_end got %b want 0", end1);
    else n_pass++;
    tick();
    valid = 1; syn = 1; err = 0;
    tick();
    valid = 0; syn = 0;
    n_chk++;
    if (sig1 !== 16'h97FE) $display("FAIL sf_sig got %h want 97FE", sig1);
    else n_pass++;
    tick();
    n_chk++;
    if (end1 !== 1'b1 || pf1 !== 1'b0)
      $display("FAIL sf_done got end=%b pf=%b want 1 0", end1, pf1);
    else n_pass++;
  endtask

  task automatic test_two_samples();
    do_reset();
    go();
    valid = 1; syn = 0; err = 0;
    tick();
    n_chk++;
    if (sig2 !== 16'h97FF || end2 !== 1'b0)
      $display("FAIL two_s1 got %h/%b want 97FF/0", sig2, end2);
    else n_pass++;
    tick();
    valid = 0;
    n_chk++;
    if (sig2 !== 16'h47FF) $display("FAIL two_s2 got %h want 47FF", sig2);
    else n_pass++;
    tick();
    n_chk++;
    if (end2 !== 1'b1 || pf2 !== 1'b0)
      $display("FAIL two_nomatch got end=%b pf=%b want 1 0", end2, pf2);
    else n_pass++;
    go();
    valid = 1;
    tick();
    syn = 1; err = 1;
    tick();
    valid = 0; syn = 0; err = 0;
    n_chk++;
    if (sig2 !== 16'h47FC) $display("FAIL two_s11 got %h want 47FC", sig2);
    else n_pass++;
    tick();
    n_chk++;
    if (end2 !== 1'b1 || pf2 !== 1'b1)
      $display("FAIL two_match got end=%b pf=%b want 1 1", end2, pf2);
    else n_pass++;
  endtask

  task automatic test_gaps();
    bit          vv [7] = '{1, 0, 0, 1, 1, 0, 1};
    bit          vs [7] = '{0, 0, 0, 1, 0, 0, 1};
    bit          ve [7] = '{0, 0, 0, 0, 1, 0, 1};
    bit          vst[7] = '{0, 0, 1, 0, 0, 1, 0};
    logic [15:0] ex [7] = '{16'h97FF, 16'h97FF, 16'h97FF, 16'h47FE,
                            16'h8FFE, 16'h8FFE, 16'h77FE};
    do_reset();
    go();
    for (int i = 0; i < 7; i++) begin
      valid = vv[i]; syn = vs[i]; err = ve[i]; start = vst[i];
      tick();
      n_chk++;
      if (sig4 !== ex[i] || end4 !== 1'b0 || busy4 !== 1'b1)
        $display("FAIL gap_step%0d got %h end=%b busy=%b want %h 0 1",
                 i, sig4, end4, busy4, ex[i]);
      else n_pass++;
    end
    valid = 0; syn = 0; err = 0; start = 0;
    tick();
    n_chk++;
    if (end4 !== 1'b1 || pf4 !== 1'b1 || sig4 !== 16'h77FE)
      $display("FAIL gap_done got %h end=%b pf=%b want 77FE 1 1",
               sig4, end4, pf4);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    go();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    n_chk++;
    if (sig1 !== 16'h0000 || busy1 !== 1'b0 || end1 !== 1'b0)
      $display("FAIL mid_rst got %h busy=%b end=%b want 0000 0 0",
               sig1, busy1, end1);
    else n_pass++;
    go();
    valid = 1;
    tick();
    valid = 0;
    tick();
    n_chk++;
    if (sig1 !== 16'h97FF || end1 !== 1'b1 || pf1 !== 1'b1)
      $display("FAIL mid_rerun got %h end=%b pf=%b want 97FF 1 1",
               sig1, end1, pf1);
    else n_pass++;
  endtask

`ifdef BIST_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    go();
    repeat (7) tick();
    n_chk++;
    if (to1 !== 1'b0 || end1 !== 1'b0)
      $display("FAIL to_early got to=%b end=%b want 0 0", to1, end1);
    else n_pass++;
    tick();
    n_chk++;
    if (to1 !== 1'b1 || end1 !== 1'b1 || pf1 !== 1'b0)
      $display("FAIL to_fire got to=%b end=%b pf=%b want 1 1 0",
               to1, end1, pf1);
    else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_chk++;
    if (to1 !== 1'b0) $display("FAIL to_clear got %b want 0", to1);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_pass();
    test_single_fail();
    test_two_samples();
    test_gaps();
    test_reset_mid();
`ifdef BIST_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bist_resp_misr.md
Name: bist_resp_misr

Overview:
- Output response analyser for the sync-detector BIST path.
- Sits directly downstream of the circuit under test and consumes its per-cycle responses (synced_d, sync_err_d) during a BIST run.
- Compacts the responses into a multiple-input signature register (MISR), compares the final signature against a golden value, and drives the top-level pass_fail and bist_end.

Parameters:
- MISR_W, 16, signature width (>= 4).
- POLY, 16'h6801, feedback tap mask for x^16+x^14+x^13+x^11+1, excluding the x^MISR_W term.
- SEED, 16'hFFFF, value loaded into the MISR at run start.
- N_PAT, 256, number of valid response samples compacted per run (>= 1).
- GOLDEN, 16'h0000, expected signature; overridden per build/bench.
- TIMEOUT, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-low.
- start  in  1  begins a run; honoured only in IDLE or DONE.
- resp_valid  in  1  CUT response sample valid this cycle.
- resp_synced  in  1  CUT synced_d output.
- resp_err  in  1  CUT sync_err_d output.
- signature  out  MISR_W  current MISR contents.
- busy  out  1  high in LOAD, COMPACT and COMPARE.
- pass_fail  out  1  1 = signature matched GOLDEN; valid while bist_end = 1.
- bist_end  out  1  run complete; held until next start or reset.

Behaviour:
- Reset (RST = 0 at an edge):
  - state = IDLE; signature = 0; count = 0.
  - pass_fail = 0, bist_end = 0, busy = 0.
  - Reset applied mid-run aborts the run; no partial result is reported.
- State machine:
  - IDLE: start = 1 -> LOAD.
  - LOAD (1 cycle): signature <= SEED; count <= 0; clear bist_end and pass_fail; go to COMPACT. resp_valid is ignored in LOAD.
  - COMPACT: on each cycle with resp_valid = 1, update the MISR and increment count. When resp_valid = 1 and count = N_PAT-1, go to COMPARE. Cycles with resp_valid = 0 hold the MISR and count.
  - COMPARE (1 cycle): pass_fail <= (signature == GOLDEN); bist_end <= 1; go to DONE. Both outputs are visible the cycle after the final MISR update edge.
  - DONE: hold signature, pass_fail and bist_end. start = 1 -> LOAD; bist_end drops on the LOAD edge.
- start in LOAD, COMPACT or COMPARE is ignored.
- MISR update (Galois, left shift), with fb = signature[MISR_W-1]:
  - next = (signature << 1) ^ (fb ? POLY : 0) ^ {0…0, resp_err, resp_synced}.
  - Bit 0 takes resp_synced; bit 1 takes resp_err.
- count is clog2(N_PAT+1) bits wide and never wraps within a run.
- An all-zero signature with all-zero data stays all-zero. This is legal and is not flagged.

Optional Feature:
- Macro: BIST_TIMEOUT_EN.
- With the macro defined:
  - An extra output timeout (1 bit, reset 0) is present.
  - A watchdog counts consecutive COMPACT cycles with resp_valid = 0 and resets to 0 on any valid sample.
  - When it reaches TIMEOUT: go to DONE with pass_fail = 0, bist_end = 1, timeout = 1. timeout clears on the next LOAD.
- Without the macro: no timeout port and no watchdog logic; COMPACT waits indefinitely.

Decomposition:
- Package bist_pkg: state enum (IDLE, LOAD, COMPACT, COMPARE, DONE), default POLY/SEED/MISR_W constants, shared with the pattern generator.
- One sub-module, bist_misr_core: parameterised MISR register with load, enable and parallel data input.
- The FSM, count and compare live in bist_resp_misr.

Test Plan:
- Single sample, pass: N_PAT=1, GOLDEN=16'h97FF; start, then one valid with synced=0, err=0 -> signature=16'h97FF, bist_end=1 and pass_fail=1 one cycle after the capture edge.
- Single sample, fail: same parameters, one valid with synced=1, err=0 -> signature=16'h97FE, pass_fail=0, bist_end=1.
- Two samples: N_PAT=2, inputs 00 then 00 -> 16'h97FF then 16'h47FF. Inputs 00 then synced=1, err=1 -> final signature 16'h47FC.
- Gaps and ignored start: N_PAT=4, resp_valid toggling 1,0,0,1,1,0,1 with start pulsed mid-run -> exactly 4 updates, run not restarted, bist_end after the 4th valid.
- Reset mid-run: RST=0 during COMPACT -> next cycle signature=0, busy=0, bist_end=0. A fresh start then reproduces the single-sample pass result.
- Timeout (BIST_TIMEOUT_EN, TIMEOUT=8): start, then no resp_valid -> 8 cycles after entering COMPACT, timeout=1, bist_end=1, pass_fail=0.
